// File: rtl/booth_mul_arbiter_pkg.sv
`default_nettype none
// ==================================================================
// Module  : booth_mul_arbiter_pkg
// Brief   : FSM encoding and default sizes for booth_mul_arbiter.
// Revision: 1.0
// ==================================================================
package booth_mul_arbiter_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_TIMEOUT = 64;
    localparam int CNT_W       = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_DROP  = 3'd2;
    localparam logic [2:0] ST_BUSY  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/booth_mul_arbiter_rr_pick.sv
`default_nettype none
// ==================================================================
// Module  : rr_pick
// Brief   : Combinational cyclic pick of the first request at/after rr_ptr.
// Revision: 1.0
// ==================================================================
module rr_pick
    import booth_mul_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = $clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    always_comb begin
        int w_idx;
        valid = |req;
        id    = '0;
        w_idx = 0;
        // Walk from the farthest offset back so the nearest hit wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = int'(rr_ptr) + k;
            if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
            if (req[w_idx[ID_W-1:0]]) id = ID_W'(w_idx);
        end
    end

endmodule
`default_nettype wire

// File: rtl/booth_mul_arbiter.sv
`default_nettype none
// ==================================================================
// Module  : booth_mul_arbiter
// Brief   : Round-robin arbiter sharing one Booth multiplier with timeout.
// Revision: 1.0
// ==================================================================
module booth_mul_arbiter
    import booth_mul_arbiter_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     op_m,
    input  logic [N_REQ*WIDTH-1:0]     op_q,
    output logic [N_REQ-1:0]           ack,
    output logic                       resp_valid,
    output logic [$clog2(N_REQ)-1:0]   resp_id,
    output logic [2*WIDTH-1:0]         resp_prod,
    output logic                       resp_err,
    output logic                       busy,
    output logic                       mul_start,
    output logic [WIDTH-1:0]           mul_m,
    output logic [WIDTH-1:0]           mul_q,
    input  logic                       mul_done,
    input  logic [2*WIDTH-1:0]         mul_prod
);

    localparam int ID_W = $clog2(N_REQ);

    logic [2:0]         r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_q;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_err;

    logic [CNT_W:0]     w_cnt_inc;
    logic               w_tmo;
    logic               w_pick_valid;
    logic [ID_W-1:0]    w_pick_id;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_ptr),
        .valid  (w_pick_valid),
        .id     (w_pick_id)
    );

    // ">=" keeps the timeout armed in BUSY if DROP's exit won the tie.
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_tmo     = (w_cnt_inc >= (CNT_W+1)'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_cnt   <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_prod  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_id    <= w_pick_id;
                        r_m     <= op_m[int'(w_pick_id)*WIDTH +: WIDTH];
                        r_q     <= op_q[int'(w_pick_id)*WIDTH +: WIDTH];
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_DROP;
                end
                ST_DROP: begin
                    r_cnt <= w_cnt_inc[CNT_W-1:0];
                    if (!mul_done) begin
                        r_state <= ST_BUSY;
                    end else if (w_tmo) begin
                        r_prod  <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= w_cnt_inc[CNT_W-1:0];
                    if (mul_done) begin
                        r_prod  <= mul_prod;
                        r_err   <= 1'b0;
                        r_state <= ST_RESP;
                    end else if (w_tmo) begin
                        r_prod  <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_ptr   <= (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mul_start  = (r_state == ST_ISSUE);
    assign busy       = (r_state != ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign ack        = resp_valid ? (N_REQ'(1) << r_id) : '0;
    assign resp_id    = r_id;
    assign resp_prod  = r_prod;
    assign resp_err   = r_err;
    assign mul_m      = r_m;
    assign mul_q      = r_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_arbiter.sv
`default_nettype none
// ==================================================================
// Module  : tb_booth_mul_arbiter
// Brief   : Randomised scoreboard bench for booth_mul_arbiter.
// Revision: 1.0
// ==================================================================
module tb_booth_mul_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TMO = 32;
    localparam int IDW = 2;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] op_m  = '0;
    logic [N*W-1:0] op_q  = '0;
    logic [N-1:0]   ack;
    logic           resp_valid;
    logic [IDW-1:0] resp_id;
    logic [2*W-1:0] resp_prod;
    logic           resp_err;
    logic           busy;
    logic           mul_start;
    logic [W-1:0]   mul_m;
    logic [W-1:0]   mul_q;
    logic           mul_done = 1'b0;
    logic [2*W-1:0] mul_prod = '0;

    typedef struct {
        int             id;
        logic [2*W-1:0] prod;
        logic           err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   mptr    = 0;
    int   dp_mode = 0;   // 0 normal, 1 never done, 2 stale done for 3 cycles
    int   dp_lat  = 4;
    logic signed [W-1:0] m_val [N];
    logic signed [W-1:0] q_val [N];

    booth_mul_arbiter #(
        .N_REQ   (N),
        .WIDTH   (W),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .op_m       (op_m),
        .op_q       (op_q),
        .ack        (ack),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_prod  (resp_prod),
        .resp_err   (resp_err),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_m      (mul_m),
        .mul_q      (mul_q),
        .mul_done   (mul_done),
        .mul_prod   (mul_prod)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] prod_of(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[2*W-1:0];
    endfunction

    // Shared multiplier model: done drops after start, rises dp_lat cycles later.
    logic [2*W-1:0] dp_new = '0;
    int dp_wait = 0;
    int dp_hold = 0;
    always @(negedge clk) begin
        if (mul_start) begin
            dp_new  = prod_of(mul_m, mul_q);
            dp_wait = dp_lat;
            if (dp_mode == 2) begin
                dp_hold = 3;
            end else begin
                dp_hold  = 0;
                mul_done = 1'b0;
            end
        end else if (dp_hold > 0) begin
            dp_hold = dp_hold - 1;
            if (dp_hold == 0) mul_done = 1'b0;
        end else if (!mul_done && dp_mode != 1) begin
            if (dp_wait == 0) begin
                mul_prod = dp_new;
                mul_done = 1'b1;
            end else begin
                dp_wait = dp_wait - 1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (resp_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL resp_unexpected: id=%0d prod=%h err=%b, none expected",
                         resp_id, resp_prod, resp_err);
            end else begin
                e = sb.pop_front();
                if (int'(resp_id) != e.id || resp_prod !== e.prod ||
                    resp_err !== e.err || ack !== (N'(1) << e.id)) begin
                    n_bad++;
                    $display("FAIL resp: got id=%0d prod=%h err=%b ack=%b, want id=%0d prod=%h err=%b",
                             resp_id, resp_prod, resp_err, ack, e.id, e.prod, e.err);
                end
            end
        end else if (ack !== '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stray_ack: got ack=%b without resp_valid, want 0", ack);
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Reference arbitration: requests raised together are served cyclically from the pointer.
    task automatic push_expect(input logic [N-1:0] mask);
        int   idx;
        int   last;
        exp_t e;
        last = mptr;
        for (int k = 0; k < N; k++) begin
            idx = (mptr + k) % N;
            if (mask[idx]) begin
                e.id   = idx;
                e.err  = (dp_mode == 1);
                e.prod = e.err ? '0 : prod_of(m_val[idx], q_val[idx]);
                sb.push_back(e);
                last = idx;
            end
        end
        mptr = (last + 1) % N;
    endtask

    task automatic launch(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            op_m[i*W +: W] = m_val[i];
            op_q[i*W +: W] = q_val[i];
        end
        push_expect(mask);
        req = req | mask;
    endtask

    task automatic drain(output int n_start, output int lat);
        int budget;
        int t0;
        n_start = 0;
        lat     = -1;
        budget  = 0;
        t0      = 0;
        while ((req != '0 || busy) && budget < 3000) begin
            @(negedge clk);
            budget++;
            if (mul_start) begin
                n_start++;
                t0 = budget;
                op_m[int'(resp_id)*W +: W] = W'($urandom);
                op_q[int'(resp_id)*W +: W] = W'($urandom);
            end
            if (resp_valid) lat = budget - t0;
            for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
        end
        if (budget >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got req=%b busy=%b after %0d cycles, want idle", req, busy, budget);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            m_val[i] = W'($urandom);
            q_val[i] = W'($urandom);
        end
    endtask

    initial begin
        int           ns;
        int           lat;
        int           b;
        logic [N-1:0] mask;

        #1 rst_n = 1'b0;
        #1;
        check("reset_outputs",
              {ack, resp_valid, resp_id, resp_prod, resp_err, busy, mul_start, mul_m, mul_q}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All four from reset: products 7,14,21,28 in order 0..3.
        for (int i = 0; i < N; i++) begin
            m_val[i] = W'(i + 1);
            q_val[i] = 16'sd7;
        end
        dp_mode = 0;
        dp_lat  = 3;
        launch(4'b1111);
        drain(ns, lat);
        check("four_req_starts", ns, 4);

        // Single job 3 * -5 with a 20-cycle datapath.
        m_val[0] = 16'sd3;
        q_val[0] = -16'sd5;
        dp_lat   = 20;
        launch(4'b0001);
        drain(ns, lat);
        check("single_job_starts", ns, 1);

        // Serve 1, then 0 and 3 together: 3 goes first.
        rand_ops();
        dp_lat = 5;
        launch(4'b0010);
        drain(ns, lat);
        rand_ops();
        launch(4'b1001);
        drain(ns, lat);
        check("rr_pair_starts", ns, 2);

        // Datapath never finishes: error response exactly TMO cycles after start.
        rand_ops();
        dp_mode = 1;
        launch(4'b0100);
        drain(ns, lat);
        check("timeout_latency", lat, TMO);
        dp_mode = 0;
        rand_ops();
        launch(4'b0100);
        drain(ns, lat);
        check("after_timeout_starts", ns, 1);

        // Stale done held 3 cycles past the new start.
        rand_ops();
        dp_mode = 2;
        dp_lat  = 4;
        launch(4'b0001);
        drain(ns, lat);
        check("stale_starts", ns, 1);
        dp_mode = 0;

        // Reset during BUSY discards the job; service restarts from index 0.
        rand_ops();
        dp_lat = 10;
        launch(4'b1010);
        b = 0;
        while (!mul_start && b < 100) begin
            @(negedge clk);
            b++;
        end
        check("reset_test_grant_seen", mul_start, 1'b1);
        repeat (3) @(negedge clk);
        check("busy_before_reset", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_midop_outputs",
              {ack, resp_valid, resp_id, resp_prod, resp_err, busy, mul_start, mul_m, mul_q}, '0);
        sb.delete();
        mptr = 0;
        push_expect(req);
        @(negedge clk);
        rst_n = 1'b1;
        drain(ns, lat);
        check("post_reset_starts", ns, 2);

        // Randomised batches.
        for (int it = 0; it < 12; it++) begin
            mask = N'($urandom_range(1, 15));
            rand_ops();
            dp_lat  = $urandom_range(1, 12);
            dp_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
            launch(mask);
            drain(ns, lat);
            check("rand_batch_starts", ns, $countones(mask));
        end
        dp_mode = 0;

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/booth_mul_arbiter.md
BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one Booth multiplier datapath, range 2..8.
REQ-002 Parameter WIDTH, default 16: signed operand width; product width is 2*WIDTH.
REQ-003 Parameter TIMEOUT, default 64: maximum cycles allowed for one multiply, counted from the cycle after mul_start, range 4..255.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req  in  N_REQ  per-requester request level; held high until the matching ack.
REQ-008 op_m  in  N_REQ*WIDTH  packed multiplicands; slice i belongs to requester i.
REQ-009 op_q  in  N_REQ*WIDTH  packed multipliers; slice i belongs to requester i.
REQ-010 ack  out  N_REQ  one-hot, one-cycle completion pulse.
REQ-011 resp_valid  out  1  one-cycle pulse, coincident with ack.
REQ-012 resp_id  out  $clog2(N_REQ)  requester being served; valid whenever busy=1.
REQ-013 resp_prod  out  2*WIDTH  signed product; valid while resp_valid=1.
REQ-014 resp_err  out  1  timeout flag; valid while resp_valid=1.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 mul_start  out  1  one-cycle start pulse to the shared datapath.
REQ-017 mul_m, mul_q  out  WIDTH each  operands to the datapath, registered, stable from ISSUE until IDLE.
REQ-018 mul_done  in  1  datapath done level; stays high until after the next start.
REQ-019 mul_prod  in  2*WIDTH  datapath product {A,Q}; valid while mul_done=1.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, DROP, BUSY and RESP.
REQ-021 IDLE: if any req bit is high, the block SHALL select the first requester at or after rr_ptr (cyclic), register its id and operands, and go to ISSUE; otherwise it stays in IDLE.
REQ-022 ISSUE: mul_start=1 for exactly this cycle; clear timeout counter; next state DROP.
REQ-023 DROP: wait for mul_done=0 so stale done from the previous job is ignored; then go to BUSY.
REQ-024 BUSY: on mul_done=1, register mul_prod into resp_prod, resp_err=0, and go to RESP.
REQ-025 In DROP and BUSY the counter SHALL increment each cycle; when it reaches TIMEOUT-1 without the exit condition, go to RESP with resp_err=1 and resp_prod=0.
REQ-026 If the exit condition and the timeout coincide in the same cycle, the exit condition SHALL win (err=0).
REQ-027 RESP: resp_valid=1 and ack[resp_id]=1 for one cycle; rr_ptr <= (resp_id+1) mod N_REQ; next state IDLE.
REQ-028 Minimum latency from grant in IDLE to resp_valid SHALL be 4 cycles (IDLE->ISSUE->DROP->BUSY->RESP) plus datapath time.
REQ-029 A req deasserted mid-operation SHALL NOT abort; the job completes and ack still pulses; the requester ignores it.
REQ-030 New requests arriving while busy=1 SHALL be held off; they are evaluated in the next IDLE cycle only.
REQ-031 A requester re-asserting req immediately after its ack SHALL be lowest priority in the next arbitration, giving a fairness bound of N_REQ-1 jobs wait.
REQ-032 Operands SHALL NOT be re-sampled after IDLE; requester operand changes after grant do not affect the job.

Reset
REQ-033 rst_n low SHALL asynchronously force: state=IDLE, rr_ptr=0, counter=0, mul_start=0, ack=0, resp_valid=0, resp_err=0, resp_prod=0, resp_id=0, mul_m=0, mul_q=0, busy=0.
REQ-034 Reset mid-operation SHALL discard the job with no ack; the first post-reset grant starts from requester 0.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (3-bit) and the default parameter constants.
REQ-036 The round-robin select SHALL be one sub-module, rr_pick (inputs req, rr_ptr; outputs valid and id), combinational.

Verification
REQ-037 WIDTH=16: req[0] with op_m=3, op_q=-5; datapath model done after 20 cycles -> one ack[0], resp_prod=32'hFFFFFFF1, resp_err=0, mul_start pulsed exactly once.
REQ-038 All four req high from reset, each op_m=i+1, op_q=7 -> acks in order 0,1,2,3 with products 7,14,21,28; each req drops after its ack.
REQ-039 rr_ptr=2 after serving 1; req[0] and req[3] high -> 3 served first, then 0.
REQ-040 Datapath model never asserts done -> resp_valid with resp_err=1 and resp_prod=0 exactly TIMEOUT cycles after mul_start; next job starts normally.
REQ-041 Stale done: mul_done held high from the previous job for 3 cycles after the new mul_start -> block stays in DROP, then returns the new product, not the old one.
REQ-042 rst_n pulsed low in BUSY -> all outputs zero immediately, no ack, next grant goes to the lowest pending index from 0.
